// File: rtl/ps4_req_agent.sv
// Requester-side agent for a 4-input fixed-priority selector.
// It keeps a pending-transaction count for each channel and drives req[i] while that count is nonzero.
// It retires one transaction per cycle on a valid grant.
// It flags starvation, dropped pushes (overflow) and protocol errors on the grant bus.
module ps4_req_agent #(
    parameter int unsigned DEPTH        = 7,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned STARVE_LIMIT = 15,
    parameter int unsigned WAIT_W       = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [3:0]           push,
    input  logic                 halt,
    input  logic [3:0]           gnt,
    output logic [3:0]           req,
    output logic                 en,
    output logic [4*CNT_W-1:0]   pend,
    output logic [3:0]           served,
    output logic [3:0]           starve,
    output logic [3:0]           ovf,
    output logic                 perr
);

    localparam int unsigned NCH = 4;

    logic [CNT_W-1:0]  cnt_q  [NCH];
    logic [CNT_W-1:0]  cnt_d  [NCH];
    logic [WAIT_W-1:0] wait_q [NCH];
    logic [WAIT_W-1:0] wait_d [NCH];
    logic [3:0]        vg_c;
    logic [3:0]        acc_c;
    logic [3:0]        drop_c;
    logic              perr_c;

    // Request and pending-count views of the per-channel counters
    always_comb begin
        req  = '0;
        pend = '0;
        for (int i = 0; i < NCH; i++) begin
            req[i]                    = (cnt_q[i] != '0);
            pend[i*CNT_W +: CNT_W]    = cnt_q[i];
        end
    end

    // Selector enable tracks halt directly
    always_comb en = ~halt;

    // Grant qualification, count update, overflow and protocol-error detection
    always_comb begin
        vg_c   = gnt & req & {4{en}};
        acc_c  = '0;
        drop_c = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            // A push at full survives only when a grant frees a slot on the same edge
            acc_c[i]  = push[i] & (((CNT_W+1)'(cnt_q[i]) < (CNT_W+1)'(DEPTH)) | vg_c[i]);
            drop_c[i] = push[i] & ~acc_c[i];
            cnt_d[i]  = CNT_W'((CNT_W+1)'(cnt_q[i]) + (CNT_W+1)'(acc_c[i])
                               - (CNT_W+1)'(vg_c[i]));
        end
        perr_c = ((gnt & (gnt - 4'd1)) != 4'd0)
               | ((gnt & ~req) != 4'd0)
               | ((|gnt) & ~en);
    end

    // Wait counters: clear on service or idle, freeze under halt, saturate at the limit
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wait_d[i] = wait_q[i];
            if (vg_c[i] || !req[i]) begin
                wait_d[i] = '0;
            end else if (halt) begin
                wait_d[i] = wait_q[i];
            end else if (req[i] && en && !gnt[i] &&
                         (wait_q[i] != WAIT_W'(STARVE_LIMIT))) begin
                wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
        end
    end

    // State and registered status outputs; reset discards all pending work
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                wait_q[i] <= '0;
            end
            served <= '0;
            starve <= '0;
            ovf    <= '0;
            perr   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                wait_q[i] <= wait_d[i];
                starve[i] <= (wait_d[i] == WAIT_W'(STARVE_LIMIT));
            end
            served <= vg_c;
            ovf    <= ovf | drop_c;
            perr   <= perr | perr_c;
        end
    end

endmodule

// File: tb/tb_ps4_req_agent.sv
// Directed bench for ps4_req_agent.
// It includes a fixed-priority selector model that can be swapped for a forced grant value.
module tb_ps4_req_agent;

    logic        clock;
    logic        reset_n;
    logic [3:0]  push;
    logic        halt;
    logic [3:0]  gnt;
    logic [3:0]  req;
    logic        en;
    logic [11:0] pend;
    logic [3:0]  served;
    logic [3:0]  starve;
    logic [3:0]  ovf;
    logic        perr;

    logic        sel_on;
    logic [3:0]  gnt_force;
    int          n_cmp;
    int          n_bad;

    ps4_req_agent dut (
        .clock  (clock),
        .reset_n(reset_n),
        .push   (push),
        .halt   (halt),
        .gnt    (gnt),
        .req    (req),
        .en     (en),
        .pend   (pend),
        .served (served),
        .starve (starve),
        .ovf    (ovf),
        .perr   (perr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Fixed-priority selector model (bit 3 highest), or a forced grant
    always_comb begin
        gnt = gnt_force;
        if (sel_on) begin
            gnt = 4'b0000;
            if (en) begin
                if (req[3])      gnt = 4'b1000;
                else if (req[2]) gnt = 4'b0100;
                else if (req[1]) gnt = 4'b0010;
                else if (req[0]) gnt = 4'b0001;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        push = '0; halt = 1'b0; sel_on = 1'b0; gnt_force = '0; reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req",    req,    0);
        chk("rst_pend",   pend,   0);
        chk("rst_served", served, 0);
        chk("rst_starve", starve, 0);
        chk("rst_ovf",    ovf,    0);
        chk("rst_perr",   perr,   0);
        chk("rst_en",     en,     1);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Single push on channel 3 with the selector active
        sel_on = 1'b1; push = 4'b1000;
        step(); push = '0;
        chk("t1_req",    req,        4'b1000);
        chk("t1_pend3",  pend[11:9], 1);
        step();
        chk("t1_served", served,     4'b1000);
        chk("t1_pend3z", pend[11:9], 0);
        chk("t1_perr",   perr,       0);
        step();
        chk("t1_srv_off", served,    0);

        // All four channels pushed once: priority retire order 3,2,1,0
        push = 4'b1111;
        step(); push = '0;
        chk("t2_req", req, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_served%0d", k), served, 4'b1000 >> k);
        end
        chk("t2_pend", pend, 0);

        // Fill channel 0 with no grants, then overflow; then push at full alongside a grant
        sel_on = 1'b0; gnt_force = '0; push = 4'b0001;
        repeat (7) step();
        chk("t3_pend0_7", pend[2:0], 7);
        chk("t3_ovf_pre", ovf,       0);
        step();
        chk("t3_ovf",     ovf,       4'b0001);
        chk("t3_pend0_f", pend[2:0], 7);
        chk("t3_req",     req,       4'b0001);
        gnt_force = 4'b0001;
        step(); push = '0; gnt_force = '0;
        chk("t3_pend0_g", pend[2:0], 7);
        chk("t3_ovf_g",   ovf,       4'b0001);
        chk("t3_srv",     served,    4'b0001);
        chk("t3_perr",    perr,      0);
        sel_on = 1'b1;
        repeat (7) step();
        chk("t3_drain",   pend,      0);

        // Starvation of channel 0 behind continuously refilled channel 3
        sel_on = 1'b0; gnt_force = '0; push = 4'b1001;
        step(); push = 4'b1000;
        step();
        chk("t4_pend3", pend[11:9], 2);
        chk("t4_pend0", pend[2:0],  1);
        sel_on = 1'b1;
        repeat (13) step();
        chk("t4_starve_pre", starve, 0);
        step();
        chk("t4_starve",   starve,     4'b0001);
        chk("t4_pend3_h",  pend[11:9], 2);
        push = '0;
        step(); step();
        chk("t4_starve_h", starve,     4'b0001);
        step();
        chk("t4_starve_c", starve,     0);
        chk("t4_srv0",     served,     4'b0001);
        chk("t4_pend",     pend,       0);

        // Halt holds everything; a grant under halt is a protocol error
        sel_on = 1'b0; gnt_force = '0; push = 4'b0010;
        repeat (3) step(); push = '0;
        halt = 1'b1;
        #1;
        chk("t5_en", en, 0);
        repeat (20) step();
        chk("t5_pend1",   pend[5:3], 3);
        chk("t5_starve",  starve,    0);
        gnt_force = 4'b0010;
        step(); gnt_force = '0;
        chk("t5_perr",    perr,      1);
        chk("t5_pend1_h", pend[5:3], 3);
        chk("t5_srv",     served,    0);
        chk("t5_ovf",     ovf,       4'b0001);
        halt = 1'b0;

        // Asynchronous reset mid-operation
        push = 4'b0100;
        repeat (4) step(); push = '0;
        chk("t6_pend2", pend[8:6], 4);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_req",    req,    0);
        chk("t6_pend",   pend,   0);
        chk("t6_served", served, 0);
        chk("t6_starve", starve, 0);
        chk("t6_ovf",    ovf,    0);
        chk("t6_perr",   perr,   0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        push = 4'b0100;
        step(); push = '0;
        chk("t6_req2",   req,       4'b0100);
        chk("t6_pend2b", pend[8:6], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
